tetris_piece_overlay: RTL
=========================

# tetris_piece_overlay

Pixel-stream overlay that renders the falling tetromino, and optionally its landing ghost, onto the playfield. It sits between the VGA scan-address generator and the final pixel mux, beside the board renderer. It is the parametrised successor of the fixed four-dot current-piece display and adds:
- configurable cell count and geometry
- per-piece colour lookup
- a two-stage pipeline
- a lock-flash state machine that keeps a locked piece blinking while the game logic spawns the next one

## Interface
Parameters:
- NUM_CELLS, 4: cells per piece.
- COL_W, 5: column field width per cell.
- ROW_W, 5: row field width per cell.
- PIX_W, 9: scan-address width.
- CELL_W, 10: cell pitch in x, in pixels.
- CELL_H, 10: cell pitch in y, in pixels.
- X_ORG, 90: playfield left pixel.
- Y_ORG, 30: playfield top pixel.
- GAP, 1: blank pixels on the low edge of each cell; legal values 0..CELL_W-1.
- FLASH_COUNT, 3: on/off blink pairs after a lock.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-low reset.
- x_addr  in  PIX_W  current scan x.
- y_addr  in  PIX_W  current scan y.
- cells  in  NUM_CELLS*(COL_W+ROW_W)  packed cells; cell i is bits [i*(COL_W+ROW_W) +: COL_W+ROW_W], formatted {col, row}.
- piece_type  in  3  tetromino id 0..6; 7 means default.
- piece_valid  in  1  live piece is drawn only when high.
- ghost_dy  in  ROW_W  ghost row offset below the live piece.
- frame_tick  in  1  one-cycle pulse per frame (vsync start).
- lock_pulse  in  1  one-cycle pulse when the piece locks.
- CurrDisplayEn  out  1  overlay pixel is opaque.
- CurrDisplayData  out  24  RGB888 pixel.
- flash_busy  out  1  lock flash is in progress.

## Operation
- Cell hit test for cell {c, r}, with bx = X_ORG + CELL_W*c and by = Y_ORG + CELL_H*r:
  - Hit when bx+GAP ≤ x_addr ≤ bx+CELL_W-1 and by+GAP ≤ y_addr ≤ by+CELL_H-1.
  - All arithmetic is unsigned, zero-extended to PIX_W+2 bits, so there is no wrap.
  - GAP=1 reproduces the legacy strict-inequality look.
- Live layer: hit on any cell AND piece_valid. Colour = COLOUR_LUT[piece_type].
- Flash layer:
  - On lock_pulse, the module snapshots cells and piece_type.
  - The snapshot is hit-tested in the same way and drawn in FLASH_COLOUR while the FSM is in FLASH_ON.
- Priority: flash > live > ghost > transparent. When transparent, CurrDisplayEn=0 and CurrDisplayData=0.
- FSM states: IDLE, FLASH_ON, FLASH_OFF. A tick counter counts down from 2*FLASH_COUNT.
  - IDLE → FLASH_ON on lock_pulse; counter loads 2*FLASH_COUNT.
  - In FLASH_ON or FLASH_OFF, each frame_tick toggles ON↔OFF and decrements the counter.
  - When the counter reaches 0, the FSM returns to IDLE.
  - lock_pulse while busy re-snapshots and restarts at FLASH_ON with a full count.
  - If lock_pulse and frame_tick arrive in the same cycle, lock_pulse wins.
- flash_busy = (state != IDLE).
- The live piece keeps rendering during the flash.
- Reset clears every output, the pipeline registers, the snapshot and the counter, and places the FSM in IDLE.

## Timing
- Latency is 2 cycles from x_addr/y_addr to CurrDisplayEn/CurrDisplayData.
  - Stage 1 registers the per-cell hit bits and the selected colours.
  - Stage 2 registers the priority-muxed enable and data.
- cells, piece_type and piece_valid are sampled with the address in stage 1. A change takes effect on the next pixel.
- FSM and snapshot update on the clock edge that samples the pulse. Flash-layer visibility follows the registered state, so a lock is visible on pixels that enter stage 1 the cycle after lock_pulse.
- Output is valid every cycle; there is no handshake.

## Configuration
- TETRIS_GHOST_EN defined: the ghost layer is built.
  - Ghost cells are {c, r+ghost_dy}, with the sum in ROW_W+1 bits and no wrap.
  - Ghost colour is the live colour with each channel shifted right by 2.
  - The ghost is gated by piece_valid.
- TETRIS_GHOST_EN undefined: the ghost_dy port remains but is ignored, and no ghost logic is generated.

## Structure
- Package tetris_disp_pkg:
  - COLOUR_LUT[0:7]; entry 7 = 24'h00FFFF.
  - FLASH_COLOUR = 24'hFFFFFF.
  - Flash FSM state enum.
  - Cell field-width defaults.
- Sub-module tetris_cell_hit, combinational: inputs are col, row and the scan address; output is the hit bit. It is instantiated per cell, per layer, through a generate loop.

## Test plan
- Defaults, cell0={2,3}, piece_type=7, piece_valid=1:
  - Scan y=65, x=110/111/119/120 → 2 cycles later, en=0/1/1/0.
  - Data=24'h00FFFF when enabled.
- piece_valid=0 with the same cells → en stays 0 for a full frame.
- lock_pulse with FLASH_COUNT=3, then 6 frame_ticks:
  - flash_busy is high for exactly 6 ticks.
  - Snapshot pixels read FFFFFF on ON frames and are transparent on OFF frames.
- lock_pulse and frame_tick in the same cycle, mid-flash → state = FLASH_ON, count restored to 6.
- Assert rst mid-flash → en=0, data=0 and flash_busy=0 immediately. After release, the FSM is IDLE.
- TETRIS_GHOST_EN defined, cell {2,3}, ghost_dy=10, piece_type=0 → pixel (115,165) shows the dimmed LUT[0]; the live pixel at (115,65) is unchanged.

Source files
------------

// File: rtl/tetris_disp_pkg.sv
// tetris_disp_pkg: colours, flash FSM states and cell field defaults
// shared by the falling-piece overlay and its cell hit tester.
package tetris_disp_pkg;
    localparam int COL_W_DEF = 5;
    localparam int ROW_W_DEF = 5;
    localparam logic [23:0] FLASH_COLOUR = 24'hFFFFFF;
    localparam logic [23:0] COLOUR_LUT [0:7] = '{
        24'h00F0F0, 24'hF0F000, 24'hA000F0, 24'h00F000,
        24'hF00000, 24'h0000F0, 24'hF0A000, 24'h00FFFF
    };
    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;
    function automatic logic [23:0] dim(input logic [23:0] c);
        return {2'b00, c[23:18], 2'b00, c[15:10], 2'b00, c[7:2]};
    endfunction
endpackage

// File: rtl/tetris_cell_hit.sv
// tetris_cell_hit: combinational test of whether the scan address lies
// inside the drawn area of one playfield cell.
module tetris_cell_hit #(
    parameter int COL_W  = 5,
    parameter int ROW_W  = 5,
    parameter int PIX_W  = 9,
    parameter int CELL_W = 10,
    parameter int CELL_H = 10,
    parameter int X_ORG  = 90,
    parameter int Y_ORG  = 30,
    parameter int GAP    = 1
) (
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic [PIX_W-1:0] x_addr,
    input  logic [PIX_W-1:0] y_addr,
    output logic             hit
);
    localparam int AW = PIX_W + 2;
    logic [AW-1:0] bx, by, x, y;
    // Two guard bits keep every bound unsigned and free of wrap.
    always_comb begin
        bx  = AW'(X_ORG) + AW'(CELL_W) * AW'(col);
        by  = AW'(Y_ORG) + AW'(CELL_H) * AW'(row);
        x   = AW'(x_addr);
        y   = AW'(y_addr);
        hit = (x >= bx + AW'(GAP)) && (x <= bx + AW'(CELL_W - 1)) &&
              (y >= by + AW'(GAP)) && (y <= by + AW'(CELL_H - 1));
    end
endmodule

// File: rtl/tetris_piece_overlay.sv
// tetris_piece_overlay: two-stage overlay of the live piece, lock flash and
// (with TETRIS_GHOST_EN defined) the landing ghost onto the scan stream.
module tetris_piece_overlay
    import tetris_disp_pkg::*;
#(
    parameter int NUM_CELLS   = 4,
    parameter int COL_W       = COL_W_DEF,
    parameter int ROW_W       = ROW_W_DEF,
    parameter int PIX_W       = 9,
    parameter int CELL_W      = 10,
    parameter int CELL_H      = 10,
    parameter int X_ORG       = 90,
    parameter int Y_ORG       = 30,
    parameter int GAP         = 1,
    parameter int FLASH_COUNT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PIX_W-1:0]                     x_addr,
    input  logic [PIX_W-1:0]                     y_addr,
    input  logic [NUM_CELLS*(COL_W+ROW_W)-1:0]   cells,
    input  logic [2:0]                           piece_type,
    input  logic                                 piece_valid,
    input  logic [ROW_W-1:0]                     ghost_dy,
    input  logic                                 frame_tick,
    input  logic                                 lock_pulse,
    output logic                                 CurrDisplayEn,
    output logic [23:0]                          CurrDisplayData,
    output logic                                 flash_busy
);
    localparam int CW    = COL_W + ROW_W;
    localparam int CNT_W = $clog2(2 * FLASH_COUNT + 1);
    flash_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [NUM_CELLS*CW-1:0] snap_cells;
    logic [NUM_CELLS-1:0] live_hit, flash_hit, s1_live, s1_flash, s1_ghost;
    logic [23:0] s1_colour, s1_ghost_colour;

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        tetris_cell_hit #(.COL_W(COL_W), .ROW_W(ROW_W), .PIX_W(PIX_W), .CELL_W(CELL_W),
                          .CELL_H(CELL_H), .X_ORG(X_ORG), .Y_ORG(Y_ORG), .GAP(GAP)) u_live (
            .col(cells[i*CW+ROW_W +: COL_W]), .row(cells[i*CW +: ROW_W]),
            .x_addr(x_addr), .y_addr(y_addr), .hit(live_hit[i]));
        tetris_cell_hit #(.COL_W(COL_W), .ROW_W(ROW_W), .PIX_W(PIX_W), .CELL_W(CELL_W),
                          .CELL_H(CELL_H), .X_ORG(X_ORG), .Y_ORG(Y_ORG), .GAP(GAP)) u_flash (
            .col(snap_cells[i*CW+ROW_W +: COL_W]), .row(snap_cells[i*CW +: ROW_W]),
            .x_addr(x_addr), .y_addr(y_addr), .hit(flash_hit[i]));
    end

`ifdef TETRIS_GHOST_EN
    logic [NUM_CELLS-1:0] ghost_hit;
    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_ghost
        logic [ROW_W:0] ghost_row;
        assign ghost_row = {1'b0, cells[g*CW +: ROW_W]} + {1'b0, ghost_dy};
        tetris_cell_hit #(.COL_W(COL_W), .ROW_W(ROW_W + 1), .PIX_W(PIX_W), .CELL_W(CELL_W),
                          .CELL_H(CELL_H), .X_ORG(X_ORG), .Y_ORG(Y_ORG), .GAP(GAP)) u_ghost (
            .col(cells[g*CW+ROW_W +: COL_W]), .row(ghost_row),
            .x_addr(x_addr), .y_addr(y_addr), .hit(ghost_hit[g]));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1_ghost        <= '0;
            s1_ghost_colour <= '0;
        end else begin
            s1_ghost        <= ghost_hit & {NUM_CELLS{piece_valid}};
            s1_ghost_colour <= dim(COLOUR_LUT[piece_type]);
        end
`else
    logic unused_ghost;
    assign unused_ghost    = ^ghost_dy;
    assign s1_ghost        = '0;
    assign s1_ghost_colour = '0;
`endif

    // A lock always wins over a frame tick and restarts the blink from the top.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flash_busy <= 1'b0;
            snap_cells <= '0;
        end else if (lock_pulse) begin
            state      <= FLASH_ON;
            cnt        <= CNT_W'(2 * FLASH_COUNT);
            flash_busy <= 1'b1;
            snap_cells <= cells;
        end else if (frame_tick && state != IDLE) begin
            cnt        <= cnt - CNT_W'(1);
            state      <= cnt == CNT_W'(1) ? IDLE : (state == FLASH_ON ? FLASH_OFF : FLASH_ON);
            flash_busy <= cnt != CNT_W'(1);
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1_live   <= '0;
            s1_flash  <= '0;
            s1_colour <= '0;
        end else begin
            s1_live   <= live_hit & {NUM_CELLS{piece_valid}};
            s1_flash  <= flash_hit & {NUM_CELLS{state == FLASH_ON}};
            s1_colour <= COLOUR_LUT[piece_type];
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            CurrDisplayEn   <= 1'b0;
            CurrDisplayData <= '0;
        end else begin
            CurrDisplayEn   <= |{s1_flash, s1_live, s1_ghost};
            CurrDisplayData <= |s1_flash ? FLASH_COLOUR :
                               |s1_live  ? s1_colour :
                               |s1_ghost ? s1_ghost_colour : 24'h0;
        end
endmodule
